// File: rtl/obf_seq_ctrl_pkg.sv
// Shared definitions for the obfuscated-instruction sequencer: widths and state encoding.
package obf_seq_ctrl_pkg;

  localparam int OBF_PPC_WIDTH = 3;
  localparam int OBF_KEY_WIDTH = 8;

  typedef enum logic {
    OBF_SEQ_IDLE  = 1'b0,
    OBF_SEQ_ISSUE = 1'b1
  } obf_seq_state_e;

  // Number of generated instructions allowed per reference before forced termination.
  function automatic int obf_max_step(input int ppc_w);
    return 1 << ppc_w;
  endfunction

endpackage

// File: rtl/obf_seq_ctrl_key_reg.sv
// Obfuscation key register: the active key only changes at a sequence boundary,
// and updates arriving mid-sequence are parked (latest wins) until that boundary.
module obf_seq_ctrl_key_reg #(
  parameter int KEY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_i,
  input  logic             key_upd_i,
  input  logic             boundary_i,
  output logic [KEY_W-1:0] key_q_o,
  output logic             key_pend_o
);

  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] key_buf;
  logic             key_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q    <= '0;
      key_buf  <= '0;
      key_pend <= 1'b0;
    end else if (boundary_i) begin
      // A same-cycle update is newer than anything parked, so it wins.
      if (key_upd_i) begin
        key_q <= key_i;
      end else if (key_pend) begin
        key_q <= key_buf;
      end
      key_pend <= 1'b0;
    end else if (key_upd_i) begin
      key_buf  <= key_i;
      key_pend <= 1'b1;
    end
  end

  assign key_q_o    = key_q;
  assign key_pend_o = key_pend;

endmodule

// File: rtl/obf_seq_ctrl.sv
// Sequencer between fetch and decode: steps the substitution pointer over one reference
// instruction, issuing one generated instruction per step until the generator reports last.
//
// Handshakes: both interfaces use strict valid/ready. A transfer happens on the rising edge
// where valid and ready are both high; the producer holds valid and payload stable until then.
// Here if_ready_o and id_valid_o are combinational from state, flush_i and id_ready_i.
module obf_seq_ctrl
  import obf_seq_ctrl_pkg::*;
#(
  parameter int PPC_W    = OBF_PPC_WIDTH,
  parameter int KEY_W    = OBF_KEY_WIDTH,
  parameter int MAX_STEP = 1 << PPC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             obf_en_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic             key_upd_i,
  input  logic             if_valid_i,
  input  logic [31:0]      if_insn_i,
  output logic             if_ready_o,
  output logic             id_valid_o,
  output logic [31:0]      id_insn_o,
  output logic             id_skip_o,
  input  logic             id_ready_i,
  input  logic             flush_i,
  output logic [31:0]      gen_ref_o,
  output logic [PPC_W-1:0] gen_ppc_o,
  output logic [KEY_W-1:0] gen_key_o,
  input  logic [31:0]      gen_insn_i,
  input  logic             gen_last_i,
  input  logic             gen_skip_i,
  output logic             busy_o,
  output logic             err_o,
  output obf_seq_state_e   dbg_state_o
);

  localparam logic [PPC_W-1:0] PPC_LAST = PPC_W'(MAX_STEP - 1);

  obf_seq_state_e   state_q, state_d;
  logic [31:0]      ref_q, ref_d;
  logic [PPC_W-1:0] ppc_q, ppc_d;
  logic             err_q, err_d;
  logic             at_max;
  logic             last_eff;
  logic             boundary;
  logic             if_ready;
  logic             id_valid;
  logic             key_pend;

  assign at_max   = (ppc_q == PPC_LAST);
  // Pass-through mode is always a single step; the pointer ceiling also forces the end.
  assign last_eff = gen_last_i | ~obf_en_i | at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OBF_SEQ_IDLE;
      ref_q   <= '0;
      ppc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      ppc_q   <= ppc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    ppc_d    = ppc_q;
    err_d    = 1'b0;
    if_ready = 1'b0;
    id_valid = 1'b0;
    boundary = 1'b0;

    if (flush_i) begin
      // Flush outranks everything: drop the reference and suppress both handshakes.
      state_d  = OBF_SEQ_IDLE;
      ppc_d    = '0;
      boundary = 1'b1;
    end else begin
      case (state_q)
        OBF_SEQ_IDLE: begin
          if_ready = 1'b1;
          boundary = 1'b1;
          if (if_valid_i) begin
            ref_d   = if_insn_i;
            ppc_d   = '0;
            state_d = OBF_SEQ_ISSUE;
          end
        end
        OBF_SEQ_ISSUE: begin
          id_valid = 1'b1;
          if (id_ready_i) begin
            if (last_eff) begin
              // Last step: reopen fetch in the same cycle so sequences run back to back.
              if_ready = 1'b1;
              boundary = 1'b1;
              ppc_d    = '0;
              err_d    = at_max & ~gen_last_i & obf_en_i;
              if (if_valid_i) begin
                ref_d = if_insn_i;
              end else begin
                state_d = OBF_SEQ_IDLE;
              end
            end else begin
              ppc_d = ppc_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = OBF_SEQ_IDLE;
        end
      endcase
    end
  end

  obf_seq_ctrl_key_reg #(
    .KEY_W(KEY_W)
  ) u_key_reg (
    .clk        (clk),
    .rst        (rst),
    .key_i      (key_i),
    .key_upd_i  (key_upd_i),
    .boundary_i (boundary),
    .key_q_o    (gen_key_o),
    .key_pend_o (key_pend)
  );

  assign if_ready_o  = if_ready;
  assign id_valid_o  = id_valid;
  assign id_insn_o   = obf_en_i ? gen_insn_i : ref_q;
  assign id_skip_o   = obf_en_i & gen_skip_i;
  assign gen_ref_o   = ref_q;
  assign gen_ppc_o   = ppc_q;
  assign busy_o      = (state_q == OBF_SEQ_ISSUE);
  // The runaway pulse is registered, so it shows in the cycle after the terminating fire.
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

  logic unused_ok;
  assign unused_ok = key_pend;

endmodule

// File: tb/tb_obf_seq_ctrl.sv
// Self-checking bench for obf_seq_ctrl with a simple combinational generator model attached.
module tb_obf_seq_ctrl;
  import obf_seq_ctrl_pkg::*;

  localparam int PPC_W = 2;
  localparam int KEY_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             obf_en_i;
  logic [KEY_W-1:0] key_i;
  logic             key_upd_i;
  logic             if_valid_i;
  logic [31:0]      if_insn_i;
  logic             if_ready_o;
  logic             id_valid_o;
  logic [31:0]      id_insn_o;
  logic             id_skip_o;
  logic             id_ready_i;
  logic             flush_i;
  logic [31:0]      gen_ref_o;
  logic [PPC_W-1:0] gen_ppc_o;
  logic [KEY_W-1:0] gen_key_o;
  logic [31:0]      gen_insn_i;
  logic             gen_last_i;
  logic             gen_skip_i;
  logic             busy_o;
  logic             err_o;
  obf_seq_state_e   dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  cur_key;
  logic [32:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  obf_seq_ctrl #(.PPC_W(PPC_W), .KEY_W(KEY_W)) dut (
    .clk(clk), .rst(rst), .obf_en_i(obf_en_i), .key_i(key_i), .key_upd_i(key_upd_i),
    .if_valid_i(if_valid_i), .if_insn_i(if_insn_i), .if_ready_o(if_ready_o),
    .id_valid_o(id_valid_o), .id_insn_o(id_insn_o), .id_skip_o(id_skip_o),
    .id_ready_i(id_ready_i), .flush_i(flush_i), .gen_ref_o(gen_ref_o),
    .gen_ppc_o(gen_ppc_o), .gen_key_o(gen_key_o), .gen_insn_i(gen_insn_i),
    .gen_last_i(gen_last_i), .gen_skip_i(gen_skip_i), .busy_o(busy_o),
    .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // Generator model: ref[2]=1 never signals last, otherwise last at ppc == ref[1:0].
  function automatic logic [31:0] gen_fn(input logic [31:0] r, input logic [1:0] p,
                                         input logic [7:0] k);
    return r ^ {k, 22'h0, p};
  endfunction

  assign gen_insn_i = gen_fn(gen_ref_o, gen_ppc_o, gen_key_o);
  assign gen_last_i = ~gen_ref_o[2] & (gen_ppc_o == gen_ref_o[1:0]);
  assign gen_skip_i = gen_ref_o[3] ^ gen_ppc_o[0];

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        obf_en;
    logic [31:0] ref_insn;
    logic [7:0]  key;
    int          exp_fires;
    logic        exp_err;
    logic [31:0] exp_first;
    logic        exp_skip;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int          fires;
    logic        err_seen;
    logic [31:0] first_insn;
    logic        first_skip;
    fires = 0; err_seen = 1'b0; first_insn = '0; first_skip = 1'b0;
    key_i = v.key; key_upd_i = 1'b1; obf_en_i = v.obf_en;
    if_insn_i = v.ref_insn; if_valid_i = 1'b1; id_ready_i = 1'b1;
    @(negedge clk);
    check("vec accept", if_ready_o, 1'b1);
    tick();
    key_upd_i = 1'b0; if_valid_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) check("vec first latency", id_valid_o, 1'b1);
      if (id_valid_o && id_ready_i) begin
        if (fires == 0) begin
          first_insn = id_insn_o;
          first_skip = id_skip_o;
        end
        fires++;
      end
      if (err_o) err_seen = 1'b1;
      tick();
    end
    check("vec fires", fires, v.exp_fires);
    check("vec err", err_seen, v.exp_err);
    check("vec first insn", first_insn, v.exp_first);
    check("vec first skip", first_skip, v.exp_skip);
    check("vec back idle", busy_o, 1'b0);
  endtask

  task automatic rand_phase(input logic en, input int cycles);
    logic [32:0] exp_w;
    logic [7:0]  k;
    int          n;
    int          exp_err;
    int          got_err;
    logic        acc;
    obf_en_i = en; if_valid_i = 1'b0; key_upd_i = 1'b0; id_ready_i = 1'b1; flush_i = 1'b0;
    exp_err = 0; got_err = 0;
    for (int c = 0; c < cycles + 40; c++) begin
      @(negedge clk);
      if (id_valid_o && id_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rand unexpected beat: got %0h expected none", id_insn_o);
        end else begin
          exp_w = exp_q.pop_front();
          check("rand beat", {id_skip_o, id_insn_o}, exp_w);
        end
      end
      if (err_o) got_err++;
      acc = if_valid_i && if_ready_o;
      if (acc) begin
        // The key a reference sees is the most recent update at or before its acceptance.
        k = key_upd_i ? key_i : cur_key;
        if (!en) begin
          exp_q.push_back({1'b0, if_insn_i});
        end else begin
          n = if_insn_i[2] ? 4 : int'(if_insn_i[1:0]) + 1;
          for (int b = 0; b < n; b++)
            exp_q.push_back({if_insn_i[3] ^ b[0], gen_fn(if_insn_i, 2'(b), k)});
          if (if_insn_i[2]) exp_err++;
        end
      end
      if (key_upd_i) cur_key = key_i;
      tick();
      if (c < cycles) begin
        if (acc || !if_valid_i) begin
          if_valid_i = ($urandom_range(0, 3) != 0);
          if_insn_i  = $urandom;
        end
        id_ready_i = ($urandom_range(0, 3) != 0);
        key_upd_i  = ($urandom_range(0, 7) == 0);
        key_i      = 8'($urandom);
      end else begin
        if_valid_i = 1'b0; id_ready_i = 1'b1; key_upd_i = 1'b0;
      end
    end
    check("rand drained", exp_q.size(), 0);
    check("rand err count", got_err, exp_err);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{1'b0, 32'hE0621800, 8'h00, 1, 1'b0, 32'hE0621800, 1'b0};
    vecs[1] = '{1'b1, 32'h00000002, 8'h00, 3, 1'b0, 32'h00000002, 1'b0};
    vecs[2] = '{1'b1, 32'h00000004, 8'h3C, 4, 1'b1, 32'h3C000004, 1'b0};
    vecs[3] = '{1'b1, 32'h00000008, 8'hA5, 1, 1'b0, 32'hA5000008, 1'b1};
    vecs[4] = '{1'b1, 32'h12345673, 8'hFF, 4, 1'b0, 32'hED345673, 1'b0};
    vecs[5] = '{1'b0, 32'h00000004, 8'h5A, 1, 1'b0, 32'h00000004, 1'b0};

    rst = 1'b1; obf_en_i = 1'b0; key_i = '0; key_upd_i = 1'b0; if_valid_i = 1'b0;
    if_insn_i = '0; id_ready_i = 1'b0; flush_i = 1'b0; cur_key = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset if_ready", if_ready_o, 1'b1);
    check("reset id_valid", id_valid_o, 1'b0);
    check("reset busy", busy_o, 1'b0);
    check("reset state", dbg_state_o, OBF_SEQ_IDLE);
    check("reset ppc", gen_ppc_o, 0);
    check("reset key", gen_key_o, 0);
    check("reset ref", gen_ref_o, 0);
    check("reset err", err_o, 1'b0);
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: A ends at ppc 2, B issues with no bubble.
    key_i = 8'h0F; key_upd_i = 1'b1; obf_en_i = 1'b1; id_ready_i = 1'b1;
    if_insn_i = 32'h00000002; if_valid_i = 1'b1;
    @(negedge clk); check("b2b accept A", if_ready_o, 1'b1);
    tick(); key_upd_i = 1'b0; if_insn_i = 32'h00000010;
    @(negedge clk);
    check("b2b ppc0 insn", id_insn_o, 32'h0F000002);
    check("b2b ppc0 if_ready", if_ready_o, 1'b0);
    tick();
    @(negedge clk);
    check("b2b ppc1", gen_ppc_o, 1);
    check("b2b ppc1 if_ready", if_ready_o, 1'b0);
    tick();
    @(negedge clk);
    check("b2b ppc2", gen_ppc_o, 2);
    check("b2b last if_ready", if_ready_o, 1'b1);
    tick(); if_valid_i = 1'b0;
    @(negedge clk);
    check("b2b no bubble", id_valid_o, 1'b1);
    check("b2b B ppc", gen_ppc_o, 0);
    check("b2b B insn", id_insn_o, 32'h0F000010);
    tick();
    @(negedge clk); check("b2b idle", busy_o, 1'b0);
    tick();

    // Stall at ppc 1, then drop obf_en at ppc 2 to force a pass-through last step.
    key_i = 8'h11; key_upd_i = 1'b1; if_insn_i = 32'h00000004; if_valid_i = 1'b1;
    @(negedge clk); tick(); key_upd_i = 1'b0; if_valid_i = 1'b0;
    @(negedge clk); tick();
    id_ready_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall ppc", gen_ppc_o, 1);
      check("stall insn", id_insn_o, 32'h11000005);
      check("stall if_ready", if_ready_o, 1'b0);
      check("stall id_valid", id_valid_o, 1'b1);
      tick();
    end
    id_ready_i = 1'b1;
    @(negedge clk); check("stall resume ppc", gen_ppc_o, 1);
    tick(); obf_en_i = 1'b0;
    @(negedge clk);
    check("passthru insn", id_insn_o, 32'h00000004);
    check("passthru skip", id_skip_o, 1'b0);
    check("passthru last", if_ready_o, 1'b1);
    tick(); obf_en_i = 1'b1;
    @(negedge clk);
    check("passthru idle", busy_o, 1'b0);
    check("passthru no err", err_o, 1'b0);
    tick();

    // Flush at ppc 1 with decode ready.
    if_insn_i = 32'h00000004; if_valid_i = 1'b1;
    @(negedge clk); tick(); if_valid_i = 1'b0;
    @(negedge clk); tick();
    flush_i = 1'b1;
    @(negedge clk);
    check("flush id_valid", id_valid_o, 1'b0);
    check("flush if_ready", if_ready_o, 1'b0);
    check("flush ppc before", gen_ppc_o, 1);
    tick(); flush_i = 1'b0;
    @(negedge clk);
    check("flush idle", dbg_state_o, OBF_SEQ_IDLE);
    check("flush ppc", gen_ppc_o, 0);
    check("flush id_valid after", id_valid_o, 1'b0);
    check("flush if_ready after", if_ready_o, 1'b1);
    tick();

    // Key update mid-sequence is deferred to the boundary.
    key_i = 8'h22; key_upd_i = 1'b1; if_insn_i = 32'h00000002; if_valid_i = 1'b1;
    @(negedge clk); tick(); key_upd_i = 1'b0; if_valid_i = 1'b0;
    @(negedge clk); check("key ppc0", gen_key_o, 8'h22);
    tick(); key_i = 8'h77; key_upd_i = 1'b1;
    @(negedge clk); check("key ppc1", gen_key_o, 8'h22);
    tick(); key_upd_i = 1'b0;
    @(negedge clk); check("key last fire", gen_key_o, 8'h22);
    tick();
    @(negedge clk);
    check("key applied", gen_key_o, 8'h77);
    check("key idle", busy_o, 1'b0);
    tick();

    // Asynchronous reset in the middle of a sequence.
    key_i = 8'h33; key_upd_i = 1'b1; if_insn_i = 32'h00000004; if_valid_i = 1'b1;
    @(negedge clk); tick(); key_upd_i = 1'b0; if_valid_i = 1'b0;
    @(negedge clk); tick();
    #2 rst = 1'b1;
    #1;
    check("areset id_valid", id_valid_o, 1'b0);
    check("areset if_ready", if_ready_o, 1'b1);
    check("areset busy", busy_o, 1'b0);
    check("areset ppc", gen_ppc_o, 0);
    check("areset ref", gen_ref_o, 0);
    check("areset key", gen_key_o, 0);
    check("areset err", err_o, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    cur_key = '0;

    rand_phase(1'b1, 500);
    rand_phase(1'b0, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
